// File: rtl/cpu_pkg.sv
// Shared core constants: address/instruction widths and the reset fetch address.
package cpu_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch front-end bus: imem request/response channels, redirect, and the IF/ID handshake.
interface instr_fetch_queue_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  import cpu_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               fq_valid;
  logic               fq_ready;
  logic [INSTR_W-1:0] fq_instr;
  logic [ADDR_W-1:0]  fq_next_pc;

  modport master (
    output imem_req_valid, imem_req_addr, fq_valid, fq_instr, fq_next_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_addr, fq_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fq_valid, fq_instr, fq_next_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_addr, fq_ready
  );
endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Generic synchronous FIFO; head data is read straight from storage, push ignored when full,
// pop ignored when empty, flush empties it and overrides push/pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o && !flush_i;
  assign do_pop    = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues imem requests, queues {instr, next_pc} for IF/ID.
// Response-to-fq_valid is one cycle; requests stall while queued + outstanding reaches DEPTH.
module instr_fetch_queue #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0]     q_count, af_count;
  logic              q_full, q_empty, af_full, af_empty;
  logic [QW-1:0]     q_head;
  logic [ADDR_W-1:0] af_head;
  logic [CW:0]       inflight;
  logic              req_valid, req_fire, rsp, rsp_keep;

  assign rsp       = bus.imem_rsp_valid;
  assign inflight  = (CW+1)'(q_count) + (CW+1)'(outst_q);
  assign req_valid = !reset && !bus.redirect && !af_full && (inflight < (CW+1)'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_keep  = rsp && (discard_q == '0) && !bus.redirect;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.fq_valid       = !q_empty && !reset;
  assign bus.fq_instr       = bus.fq_valid ? q_head[QW-1:ADDR_W] : '0;
  assign bus.fq_next_pc     = bus.fq_valid ? q_head[ADDR_W-1:0] : '0;

  // Redirect takes the discard count from the pre-flush outstanding total.
  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(rsp);
    discard_d = discard_q;
    if (bus.redirect) begin
      pc_d      = bus.redirect_addr;
      discard_d = outst_q - CW'(rsp);
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(1);
      if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push_i    (rsp_keep),
    .pop_i     (bus.fq_valid && bus.fq_ready),
    .flush_i   (bus.redirect),
    .wr_data_i ({bus.imem_rsp_data, af_head + ADDR_W'(1)}),
    .rd_data_o (q_head),
    .full_o    (q_full),
    .empty_o   (q_empty),
    .count_o   (q_count)
  );

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .reset     (reset),
    .push_i    (req_fire),
    .pop_i     (rsp_keep),
    .flush_i   (bus.redirect),
    .wr_data_i (pc_q),
    .rd_data_o (af_head),
    .full_o    (af_full),
    .empty_o   (af_empty),
    .count_o   (af_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(rsp && q_full));
  a_addr_track:  assert property (@(posedge clk) disable iff (reset) !(rsp_keep && af_empty));
  a_af_count:    assert property (@(posedge clk) disable iff (reset) af_count == outst_q - discard_q);
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the pipelined MIPS core.
- Owns the program counter and issues word-addressed requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their sequential next-PC in a small queue.
- Presents them to the IF/ID pipeline register through a valid/ready handshake.
- Branch and jump redirects from the pipeline flush the queue and discard in-flight responses.

## Interface
- ADDR_W, 32, PC / address width; the PC is a word address and increments by 1.
- DEPTH, 4, queue entries; also the cap on requests that are queued plus outstanding. Power of two, ≥2.
- RESET_PC, 0, PC value loaded by reset.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  word address being fetched.
- imem_rsp_valid  in  1  response data valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect  in  1  taken branch/jump (PCSrc).
- redirect_addr  in  ADDR_W  new fetch address.
- fq_valid  out  1  head entry valid.
- fq_ready  in  1  IF/ID accepts the entry (IRWrite).
- fq_instr  out  32  head instruction.
- fq_next_pc  out  ADDR_W  head fetch address + 1.

## Operation
- Registers:
  - pc: next address to request.
  - outstanding: number of accepted requests not yet answered, 0..DEPTH.
  - discard: responses still to be dropped, 0..DEPTH.
  - queue: entries holding {instr, next_pc}, plus count.
- Issue rule: imem_req_valid = !redirect && (count + outstanding < DEPTH).
  - imem_req_addr = pc.
  - On accept: pc <= pc+1 (wraps modulo 2^ADDR_W) and outstanding increments.
- Response with discard==0: push {imem_rsp_data, addr+1} and decrement outstanding.
  - The fetch address for each response is tracked in a DEPTH-entry address FIFO written on request accept.
- Response with discard>0: drop it and decrement both discard and outstanding.
- Pop: fq_valid && fq_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - queue count <= 0 and pc <= redirect_addr.
  - discard <= outstanding minus any response arriving that same cycle; that response is also dropped.
  - No request is issued that cycle.
  - A simultaneous pop is ignored because the queue is flushed.
- The issue rule makes queue overflow impossible; a response arriving with count==DEPTH is an assertion failure.
- Reset:
  - pc=RESET_PC; outstanding, discard and count all 0.
  - imem_req_valid=0 and fq_valid=0 during the reset cycle; fq_instr and fq_next_pc = 0.
  - Reset mid-operation abandons outstanding requests. The memory is reset by the same signal, so no response arrives after reset.

## Timing
- Queue outputs are driven from registers. There is no combinational path from imem_rsp_* or fq_ready to fq_* outputs.
- imem_req_valid depends combinationally on redirect and internal state only, never on imem_req_ready.
- Response captured at edge N → fq_valid in cycle N+1.
- With 1-cycle memory and redirect in cycle R:
  - First request in R+1.
  - Response in R+2.
  - fq_valid in R+3.
- Sustained throughput is 1 instruction/cycle with memory latency ≤ DEPTH-2 and fq_ready held high.
- First request after reset deasserts: the cycle immediately after, address RESET_PC.

## Structure
- cpu_pkg holds ADDR_W, INSTR_W=32 and RESET_PC.
- One sub-module, fetch_fifo, a generic synchronous FIFO:
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, flush, full, empty, count, head data.
  - Instantiated twice: the instruction/next-PC queue, and the in-flight address FIFO (flushed on redirect only after the discard count is taken).
- Counters and redirect logic sit in the top module.

## Test plan
- Reset, 1-cycle memory returning addr×4, fq_ready=1 → requests to addresses 0,1,2,…; fq outputs {0,1},{4,2},{8,3}, one per cycle from cycle 3.
- fq_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req_valid=0. Release → entries pop in order with no loss or duplication.
- imem_req_ready toggling 1,0,1,0 → imem_req_addr holds stable while not accepted. Output sequence is contiguous.
- 3-cycle memory with 2 requests outstanding, redirect to 0x40 → both stale responses dropped. First fq entry is {mem[0x40], 0x41}. fq_valid stays 0 until then.
- Redirect in the same cycle as a response and a pop → response dropped, queue empty next cycle, next request to redirect_addr.
- Reset asserted with 3 entries queued and 1 outstanding → next cycle fq_valid=0, imem_req_valid=0. First request after reset is address RESET_PC.
